// File: rtl/dreq_wr_data_framer_pkg.sv
// dreq_wr_data_framer_pkg: shared request/frame types and the request-to-frame conversion.
package dreq_wr_data_framer_pkg;
  localparam int AXI_DATA_BITS = 512;
  localparam int LEN_BITS = 28;
  localparam int VADDR_BITS = 48;
  localparam int BLEN_BITS = 4;
  localparam int BYTES_W = AXI_DATA_BITS / 8;
  localparam int BEAT_LOG_BITS = $clog2(BYTES_W);
  typedef logic [BYTES_W-1:0] keep_t;
  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
  } req_t;
  typedef struct packed {
    req_t req_1;
    req_t req_2;
  } dreq_t;
  typedef struct packed {
    logic [BLEN_BITS:0] beats;
    keep_t              last_keep;
  } wr_frame_t;
  typedef enum logic {ST_IDLE, ST_XFER} framer_state_t;
  // Only the low length bits matter: frames longer than the data FIFO are illegal anyway.
  function automatic wr_frame_t mk_frame(input logic [BEAT_LOG_BITS+BLEN_BITS:0] len);
    wr_frame_t f;
    logic [BEAT_LOG_BITS-1:0] rem;
    rem = len[BEAT_LOG_BITS-1:0];
    f.beats = len[BEAT_LOG_BITS+BLEN_BITS:BEAT_LOG_BITS] + (BLEN_BITS+1)'(rem != '0);
    f.last_keep = (rem == '0) ? '1 : (keep_t'(1) << rem) - keep_t'(1);
    return f;
  endfunction
endpackage

// File: rtl/dreq_wr_len_queue.sv
// dreq_wr_len_queue: first-word-fall-through synchronous FIFO with full/empty flags.
module dreq_wr_len_queue
  import dreq_wr_data_framer_pkg::*;
#(
  parameter type T     = wr_frame_t,
  parameter int  DEPTH = 8
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_pop   = i_pop & !o_empty;
  assign w_push  = i_push & (!o_full | w_pop);
  assign o_data  = r_mem[r_rp];
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wp] <= i_data;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/dreq_wr_data_framer.sv
// dreq_wr_data_framer: buffers user write beats and frames them per issued request
// (beat count, tlast, last-beat tkeep) toward the shell.
module dreq_wr_data_framer
  import dreq_wr_data_framer_pkg::*;
#(
  parameter int DATA_BITS  = AXI_DATA_BITS,
  parameter int DATA_DEPTH = 2**BLEN_BITS,
  parameter int REQ_DEPTH  = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  dreq_t                  i_req_data,
  input  logic [DATA_BITS-1:0]   i_s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] i_s_axis_tkeep,
  input  logic                   i_s_axis_tlast,
  input  logic                   i_s_axis_tvalid,
  output logic                   o_s_axis_tready,
  output logic [DATA_BITS-1:0]   o_m_axis_tdata,
  output logic [DATA_BITS/8-1:0] o_m_axis_tkeep,
  output logic                   o_m_axis_tlast,
  output logic                   o_m_axis_tvalid,
  input  logic                   i_m_axis_tready,
  output logic                   o_xfer
);
  localparam int BYTES = DATA_BITS / 8;
  localparam logic [BLEN_BITS:0] ONE = 1;
  localparam logic [BLEN_BITS:0] MAX_BEATS = (BLEN_BITS+1)'(DATA_DEPTH);
  typedef struct packed {
    logic [DATA_BITS-1:0] tdata;
    logic [BYTES-1:0]     tkeep;
  } beat_t;
  framer_state_t r_state, w_state_nxt;
  logic [BLEN_BITS:0] r_cnt, w_cnt_nxt;
  logic [BYTES-1:0] r_keep_l, w_keep_nxt;
  wr_frame_t w_len_head;
  beat_t w_head, w_s_beat;
  logic w_len_full, w_len_empty, w_len_pop, w_data_full, w_data_empty;
  logic w_m_hs, w_last_hs, w_unused;
  assign w_unused = ^{i_s_axis_tlast, i_req_data.req_2, i_req_data.req_1.vaddr,
                      i_req_data.req_1.len[LEN_BITS-1:BEAT_LOG_BITS+BLEN_BITS+1]};
  // Ready is held low during reset so nothing is accepted into flushing queues.
  assign o_req_ready     = aresetn & !w_len_full;
  assign o_s_axis_tready = aresetn & !w_data_full;
  assign o_xfer          = i_s_axis_tvalid & o_s_axis_tready;
  assign w_s_beat        = '{tdata: i_s_axis_tdata, tkeep: i_s_axis_tkeep};
  dreq_wr_len_queue #(.T(wr_frame_t), .DEPTH(REQ_DEPTH)) u_len_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_push  (i_req_valid & o_req_ready),
    .i_data  (mk_frame(i_req_data.req_1.len[BEAT_LOG_BITS+BLEN_BITS:0])),
    .i_pop   (w_len_pop),
    .o_data  (w_len_head),
    .o_full  (w_len_full),
    .o_empty (w_len_empty)
  );
  dreq_wr_len_queue #(.T(beat_t), .DEPTH(DATA_DEPTH)) u_data_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_push  (o_xfer),
    .i_data  (w_s_beat),
    .i_pop   (w_m_hs),
    .o_data  (w_head),
    .o_full  (w_data_full),
    .o_empty (w_data_empty)
  );
  assign o_m_axis_tvalid = (r_state == ST_XFER) & !w_data_empty;
  assign o_m_axis_tlast  = (r_state == ST_XFER) & (r_cnt == ONE);
  assign o_m_axis_tdata  = w_head.tdata;
  assign o_m_axis_tkeep  = w_head.tkeep & ((r_cnt == ONE) ? r_keep_l : '1);
  assign w_m_hs          = o_m_axis_tvalid & i_m_axis_tready;
  assign w_last_hs       = w_m_hs & o_m_axis_tlast;
  // Next request is taken on the last-beat handshake so frames run back to back.
  always_comb begin
    w_len_pop   = 1'b0;
    w_state_nxt = w_last_hs ? ST_IDLE : r_state;
    w_cnt_nxt   = w_m_hs ? r_cnt - ONE : r_cnt;
    w_keep_nxt  = r_keep_l;
    if ((r_state == ST_IDLE || w_last_hs) && !w_len_empty) begin
      w_len_pop   = 1'b1;
      w_state_nxt = (w_len_head.beats == '0) ? ST_IDLE : ST_XFER;
      w_cnt_nxt   = w_len_head.beats;
      w_keep_nxt  = w_len_head.last_keep;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_keep_l <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_keep_l <= w_keep_nxt;
    end
  end
  always_ff @(posedge aclk)
    if (aresetn && w_len_pop) assert (w_len_head.beats <= MAX_BEATS);
endmodule

// File: tb/tb_dreq_wr_data_framer.sv
// tb_dreq_wr_data_framer: directed checks of request framing, backpressure and reset flush.
module tb_dreq_wr_data_framer;
  import dreq_wr_data_framer_pkg::*;
  localparam logic [63:0] ONES = '1;
  logic aclk = 1'b0;
  logic aresetn;
  logic i_req_valid, o_req_ready;
  dreq_t i_req_data;
  logic [511:0] i_s_axis_tdata, o_m_axis_tdata;
  logic [63:0] i_s_axis_tkeep, o_m_axis_tkeep;
  logic i_s_axis_tlast, i_s_axis_tvalid, o_s_axis_tready;
  logic o_m_axis_tlast, o_m_axis_tvalid, i_m_axis_tready, o_xfer;
  int n_assert = 0, n_fail = 0, n_xfer = 0, cyc = 0;
  logic [63:0] q_data[$], q_keep[$];
  logic q_last[$];
  int q_cyc[$];

  dreq_wr_data_framer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_data      (i_req_data),
    .i_s_axis_tdata  (i_s_axis_tdata),
    .i_s_axis_tkeep  (i_s_axis_tkeep),
    .i_s_axis_tlast  (i_s_axis_tlast),
    .i_s_axis_tvalid (i_s_axis_tvalid),
    .o_s_axis_tready (o_s_axis_tready),
    .o_m_axis_tdata  (o_m_axis_tdata),
    .o_m_axis_tkeep  (o_m_axis_tkeep),
    .o_m_axis_tlast  (o_m_axis_tlast),
    .o_m_axis_tvalid (o_m_axis_tvalid),
    .i_m_axis_tready (i_m_axis_tready),
    .o_xfer          (o_xfer)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;
  always @(negedge aclk) begin
    if (o_xfer) n_xfer++;
    if (o_m_axis_tvalid && i_m_axis_tready) begin
      q_data.push_back(o_m_axis_tdata[63:0]);
      q_keep.push_back(o_m_axis_tkeep);
      q_last.push_back(o_m_axis_tlast);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic clear();
    n_xfer = 0;
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_cyc.delete();
  endtask
  task automatic req(input int len);
    i_req_valid = 1'b1;
    i_req_data = '0;
    i_req_data.req_1.len = LEN_BITS'(len);
    i_req_data.req_1.vaddr = 48'h1000;
    for (int k = 0; k < 50 && !o_req_ready; k++) step();
    step();
    i_req_valid = 1'b0;
  endtask
  task automatic send(input int id, input int n);
    for (int j = 0; j < n; j++) begin
      i_s_axis_tvalid = 1'b1;
      i_s_axis_tdata = 512'(id + j);
      for (int k = 0; k < 50 && !o_s_axis_tready; k++) step();
      step();
    end
    i_s_axis_tvalid = 1'b0;
  endtask
  task automatic wait_beats(input string tag, input int n);
    for (int k = 0; k < 200 && q_data.size() < n; k++) step();
    chk(tag, 64'(q_data.size()), 64'(n));
  endtask

  initial begin
    aresetn = 1'b0;
    i_req_valid = 1'b1;
    i_req_data = '0;
    i_s_axis_tdata = '0;
    i_s_axis_tkeep = '1;
    i_s_axis_tlast = 1'b1;
    i_s_axis_tvalid = 1'b1;
    i_m_axis_tready = 1'b1;
    step();
    step();
    chk("rst_req_ready", 64'(o_req_ready), 0);
    chk("rst_s_tready", 64'(o_s_axis_tready), 0);
    chk("rst_m_tvalid", 64'(o_m_axis_tvalid), 0);
    chk("rst_m_tlast", 64'(o_m_axis_tlast), 0);
    chk("rst_xfer", 64'(o_xfer), 0);
    aresetn = 1'b1;
    i_req_valid = 1'b0;
    i_s_axis_tvalid = 1'b0;
    step();
    chk("idle_req_ready", 64'(o_req_ready), 1);
    chk("idle_s_tready", 64'(o_s_axis_tready), 1);
    // 1: len=256 -> four full beats
    clear();
    req(256);
    send(1, 4);
    wait_beats("t1_beats", 4);
    chk("t1_xfer", 64'(n_xfer), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_last%0d", i), 64'(q_last[i]), 64'(i == 3));
      chk($sformatf("t1_keep%0d", i), q_keep[i], ONES);
      chk($sformatf("t1_data%0d", i), q_data[i], 64'(i + 1));
    end
    // 2: len=100 -> two beats, 36 valid bytes in the last
    clear();
    req(100);
    send(11, 2);
    wait_beats("t2_beats", 2);
    chk("t2_last0", 64'(q_last[0]), 0);
    chk("t2_last1", 64'(q_last[1]), 1);
    chk("t2_keep0", q_keep[0], ONES);
    chk("t2_keep1", q_keep[1], 64'h0000_000F_FFFF_FFFF);
    // 3: two len=128 requests, continuous data, no bubble
    clear();
    req(128);
    req(128);
    send(21, 4);
    wait_beats("t3_beats", 4);
    chk("t3_gap", 64'(q_cyc[3] - q_cyc[0]), 3);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_last%0d", i), 64'(q_last[i]), 64'(i % 2 == 1));
    chk("t3_data3", q_data[3], 24);
    // 4: data FIFO fills at 16 with no request and tready low
    clear();
    i_m_axis_tready = 1'b0;
    i_s_axis_tvalid = 1'b1;
    i_s_axis_tdata = 512'd100;
    for (int k = 0; k < 20; k++) step();
    i_s_axis_tvalid = 1'b0;
    chk("t4_xfer", 64'(n_xfer), 16);
    chk("t4_full_tready", 64'(o_s_axis_tready), 0);
    chk("t4_idle_tvalid", 64'(o_m_axis_tvalid), 0);
    i_m_axis_tready = 1'b1;
    req(1024);
    wait_beats("t4_beats", 16);
    chk("t4_last14", 64'(q_last[14]), 0);
    chk("t4_last15", 64'(q_last[15]), 1);
    chk("t4_drain_tready", 64'(o_s_axis_tready), 1);
    // 5: len=0 is discarded, len=64 gives one beat
    clear();
    req(0);
    req(64);
    send(50, 1);
    wait_beats("t5_beats", 1);
    chk("t5_last", 64'(q_last[0]), 1);
    chk("t5_data", q_data[0], 50);
    send(51, 1);
    for (int k = 0; k < 5; k++) step();
    chk("t5_no_extra", 64'(q_data.size()), 1);
    chk("t5_buffered_idle", 64'(o_m_axis_tvalid), 0);
    // 6: reset in the middle of a 4-beat frame (51 is still buffered from above)
    clear();
    req(256);
    send(61, 1);
    wait_beats("t6_beats", 2);
    chk("t6_data0", q_data[0], 51);
    chk("t6_data1", q_data[1], 61);
    i_m_axis_tready = 1'b0;
    send(62, 1);
    chk("t6_hold_tvalid", 64'(o_m_axis_tvalid), 1);
    chk("t6_hold_tlast", 64'(o_m_axis_tlast), 0);
    step();
    step();
    chk("t6_hold_tdata", o_m_axis_tdata[63:0], 62);
    aresetn = 1'b0;
    i_s_axis_tvalid = 1'b1;
    i_req_valid = 1'b1;
    step();
    chk("t6_rst_tvalid", 64'(o_m_axis_tvalid), 0);
    chk("t6_rst_tlast", 64'(o_m_axis_tlast), 0);
    chk("t6_rst_req_ready", 64'(o_req_ready), 0);
    chk("t6_rst_s_tready", 64'(o_s_axis_tready), 0);
    chk("t6_rst_xfer", 64'(o_xfer), 0);
    aresetn = 1'b1;
    i_s_axis_tvalid = 1'b0;
    i_req_valid = 1'b0;
    i_m_axis_tready = 1'b1;
    clear();
    step();
    chk("t6_flushed", 64'(o_m_axis_tvalid), 0);
    send(71, 1);
    step();
    chk("t6_no_req_tvalid", 64'(o_m_axis_tvalid), 0);
    req(64);
    chk("t6_lat_t1", 64'(o_m_axis_tvalid), 0);
    step();
    chk("t6_lat_t2", 64'(o_m_axis_tvalid), 1);
    chk("t6_post_tdata", o_m_axis_tdata[63:0], 71);
    chk("t6_post_tkeep", o_m_axis_tkeep, ONES);
    wait_beats("t6_post_beats", 1);
    chk("t6_post_last", 64'(q_last[0]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
